// File: rtl/mem_ctrl.sv
// CPU-to-main-memory access controller: one outstanding read/write, ACK timeout, registered outputs.
// Optional alignment check when MEM_CTRL_ALIGN_CHECK_EN is defined.
module mem_ctrl #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                     MEM_CTRL_CLOCK_50,
    input  logic                     MEM_CTRL_RESET_InHigh,
    input  logic                     MEM_CTRL_CPU_RD_In,
    input  logic                     MEM_CTRL_CPU_WR_In,
    input  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_CPU_ADDRESS_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_CPU_data_InBUS,
    output logic [DATAWIDTH_BUS-1:0] MEM_CTRL_CPU_data_OutBUS,
    output logic                     MEM_CTRL_CPU_BUSY_Out,
    output logic                     MEM_CTRL_CPU_DONE_Out,
    output logic                     MEM_CTRL_CPU_ERROR_Out,
    output logic                     MEM_CTRL_MEM_RD_Out,
    output logic                     MEM_CTRL_MEM_WR_Out,
    output logic [DATAWIDTH_BUS-1:0] MEM_CTRL_MEM_ADDRESS_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MEM_CTRL_MEM_data_OutBUS,
    input  logic [DATAWIDTH_BUS-1:0] MEM_CTRL_MEM_data_InBUS,
    input  logic                     MEM_CTRL_MEM_ACK_In
);

    // state  | meaning
    // IDLE   | waiting for a single CPU request
    // ACCESS | strobe to memory asserted, waiting for ACK or timeout
    // DONE   | one-cycle completion pulse
    // ERR    | one-cycle abort pulse (conflict, timeout, misalignment)
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t     state;
    state_t     next_state;
    logic [7:0] timeout_cnt;
    logic [7:0] timeout_cnt_next;
    logic [7:0] cnt_inc;
    logic       dir_wr;
    logic       dir_wr_next;
    logic       req_one;
    logic       req_both;
    logic       misaligned;
    logic       accept;
    logic       rd_capture;
    logic       busy_d;
    logic       done_d;
    logic       error_d;
    logic       mem_rd_d;
    logic       mem_wr_d;

    always_comb begin
        req_both = MEM_CTRL_CPU_RD_In & MEM_CTRL_CPU_WR_In;
        req_one  = MEM_CTRL_CPU_RD_In ^ MEM_CTRL_CPU_WR_In;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        misaligned = req_one && (MEM_CTRL_CPU_ADDRESS_InBUS[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        accept      = (state == IDLE) && req_one && !misaligned;
        rd_capture  = (state == ACCESS) && MEM_CTRL_MEM_ACK_In && !dir_wr;
        dir_wr_next = accept ? MEM_CTRL_CPU_WR_In : dir_wr;
        // Saturating increment: the counter must never wrap back to zero.
        cnt_inc     = (timeout_cnt == 8'hFF) ? 8'hFF : timeout_cnt + 8'd1;
    end

    always_comb begin
        next_state       = state;
        timeout_cnt_next = timeout_cnt;
        case (state)
            IDLE: begin
                if (req_both || misaligned) begin
                    next_state = ERR;
                end else if (req_one) begin
                    next_state       = ACCESS;
                    timeout_cnt_next = 8'd0;
                end
            end
            ACCESS: begin
                if (MEM_CTRL_MEM_ACK_In) begin
                    next_state       = DONE;
                    timeout_cnt_next = 8'd0;
                end else begin
                    timeout_cnt_next = cnt_inc;
                    if (cnt_inc >= TIMEOUT_LIMIT) begin
                        next_state = ERR;
                    end
                end
            end
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        busy_d   = (next_state != IDLE);
        done_d   = (next_state == DONE);
        error_d  = (next_state == ERR);
        mem_rd_d = (next_state == ACCESS) && !dir_wr_next;
        mem_wr_d = (next_state == ACCESS) &&  dir_wr_next;
    end

    always_ff @(posedge MEM_CTRL_CLOCK_50) begin
        if (MEM_CTRL_RESET_InHigh) begin
            state                       <= IDLE;
            timeout_cnt                 <= 8'd0;
            dir_wr                      <= 1'b0;
            MEM_CTRL_CPU_data_OutBUS    <= '0;
            MEM_CTRL_MEM_ADDRESS_OutBUS <= '0;
            MEM_CTRL_MEM_data_OutBUS    <= '0;
            MEM_CTRL_CPU_BUSY_Out       <= 1'b0;
            MEM_CTRL_CPU_DONE_Out       <= 1'b0;
            MEM_CTRL_CPU_ERROR_Out      <= 1'b0;
            MEM_CTRL_MEM_RD_Out         <= 1'b0;
            MEM_CTRL_MEM_WR_Out         <= 1'b0;
        end else begin
            state       <= next_state;
            timeout_cnt <= timeout_cnt_next;
            dir_wr      <= dir_wr_next;
            if (accept) begin
                MEM_CTRL_MEM_ADDRESS_OutBUS <= MEM_CTRL_CPU_ADDRESS_InBUS;
                MEM_CTRL_MEM_data_OutBUS    <= MEM_CTRL_CPU_data_InBUS;
            end
            if (rd_capture) begin
                MEM_CTRL_CPU_data_OutBUS <= MEM_CTRL_MEM_data_InBUS;
            end
            MEM_CTRL_CPU_BUSY_Out  <= busy_d;
            MEM_CTRL_CPU_DONE_Out  <= done_d;
            MEM_CTRL_CPU_ERROR_Out <= error_d;
            MEM_CTRL_MEM_RD_Out    <= mem_rd_d;
            MEM_CTRL_MEM_WR_Out    <= mem_wr_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed accesses, memory ACK model, pulse monitor.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    typedef struct packed {
        logic        is_err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_lat = -1;
    int          strobe_age = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;

    mem_ctrl #(.DATAWIDTH_BUS(32), .TIMEOUT_CYCLES(8)) dut (
        .MEM_CTRL_CLOCK_50          (clk),
        .MEM_CTRL_RESET_InHigh      (rst),
        .MEM_CTRL_CPU_RD_In         (cpu_rd),
        .MEM_CTRL_CPU_WR_In         (cpu_wr),
        .MEM_CTRL_CPU_ADDRESS_InBUS (cpu_addr),
        .MEM_CTRL_CPU_data_InBUS    (cpu_wdata),
        .MEM_CTRL_CPU_data_OutBUS   (cpu_rdata),
        .MEM_CTRL_CPU_BUSY_Out      (busy),
        .MEM_CTRL_CPU_DONE_Out      (done),
        .MEM_CTRL_CPU_ERROR_Out     (error),
        .MEM_CTRL_MEM_RD_Out        (mem_rd),
        .MEM_CTRL_MEM_WR_Out        (mem_wr),
        .MEM_CTRL_MEM_ADDRESS_OutBUS(mem_addr),
        .MEM_CTRL_MEM_data_OutBUS   (mem_wdata),
        .MEM_CTRL_MEM_data_InBUS    (mem_rdata),
        .MEM_CTRL_MEM_ACK_In        (mem_ack)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model + monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (mem_rd || mem_wr) begin
            if (mem_rd) rd_cycles++;
            if (mem_wr) wr_cycles++;
            check("strobe_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
            check("mem_addr_stable", mem_addr, exp_addr);
            check("mem_wdata_stable", mem_wdata, exp_wdata);
            mem_ack = (ack_lat >= 0) && (strobe_age == ack_lat);
            strobe_age++;
        end else begin
            mem_ack    = 1'b0;
            strobe_age = 0;
        end
        if (!rst && (done || error)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, done, error}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind", {30'd0, done, error}, e.is_err ? 32'd1 : 32'd2);
                check("cpu_rdata", cpu_rdata, e.rdata);
            end
        end
    end

    // Starts at posedge+1; leaves at posedge+1 just after the accepting edge.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
        ack_lat   = lat;
        mem_rdata = rdata;
        exp_addr  = addr;
        exp_wdata = wdata;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int rd0, wr0, n;
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int wr0;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        check("rst_pulses", {30'd0, done, error}, 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Read 0x800, ACK on first access cycle: minimum latency
        rd0 = rd_cycles; wr0 = wr_cycles;
        sb_q.push_back('{is_err: 1'b0, rdata: 32'hC600_2001});
        issue(1'b1, 1'b0, 32'h800, 32'h0, 32'hC600_2001, 0);
        check("rd_strobe_n", {31'd0, mem_rd}, 32'd1);
        @(posedge clk); #1;
        check("done_n1", {31'd0, done}, 32'd1);
        check("rd_low_n1", {31'd0, mem_rd}, 32'd0);
        check("busy_n1", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("done_gone_n2", {31'd0, done}, 32'd0);
        check("idle_n2", {31'd0, busy}, 32'd0);
        check("read_rd_cycles", rd_cycles - rd0, 32'd1);
        check("read_wr_cycles", wr_cycles - wr0, 32'd0);

        // Write 0x804, ACK after 3 cycles; read data must not change
        rd0 = rd_cycles; wr0 = wr_cycles;
        sb_q.push_back('{is_err: 1'b0, rdata: 32'hC600_2001});
        issue(1'b0, 1'b1, 32'h804, 32'h1234_5678, 32'hDEAD_BEEF, 2);
        wait_idle("write_idle");
        check("write_wr_cycles", wr_cycles - wr0, 32'd3);
        check("write_rd_cycles", rd_cycles - rd0, 32'd0);
        check("write_keeps_rdata", cpu_rdata, 32'hC600_2001);

        // Read 0x808, no ACK: timeout after 8 access cycles
        rd0 = rd_cycles;
        sb_q.push_back('{is_err: 1'b1, rdata: 32'hC600_2001});
        issue(1'b1, 1'b0, 32'h808, 32'h0, 32'h5555_AAAA, -1);
        n = 0;
        while (!error && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_error_seen", {31'd0, error}, 32'd1);
        check("timeout_strobe_low", {31'd0, mem_rd}, 32'd0);
        @(posedge clk); #1;
        check("timeout_busy_low", {31'd0, busy}, 32'd0);
        check("timeout_rd_cycles", rd_cycles - rd0, 32'd8);

        // RD and WR together: immediate error, no strobe
        rd0 = rd_cycles; wr0 = wr_cycles;
        sb_q.push_back('{is_err: 1'b1, rdata: 32'hC600_2001});
        issue(1'b1, 1'b1, 32'h830, 32'h0, 32'h0, 0);
        check("conflict_error", {31'd0, error}, 32'd1);
        check("conflict_no_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
        @(posedge clk); #1;
        check("conflict_idle", {31'd0, busy}, 32'd0);
        check("conflict_strobe_cnt", (rd_cycles - rd0) + (wr_cycles - wr0), 32'd0);

        // Read 0x810 with CPU_WR toggling while busy: only the one read happens
        rd0 = rd_cycles; wr0 = wr_cycles;
        sb_q.push_back('{is_err: 1'b0, rdata: 32'hAABB_CCDD});
        issue(1'b1, 1'b0, 32'h810, 32'h0, 32'hAABB_CCDD, 2);
        for (int i = 0; i < 4; i++) begin
            cpu_wr = (i % 2 == 0);
            cpu_addr = 32'hFFFF_FFFC;
            @(posedge clk); #1;
        end
        cpu_wr = 1'b0;
        wait_idle("toggle_idle");
        repeat (3) @(posedge clk);
        #1;
        check("toggle_rd_cycles", rd_cycles - rd0, 32'd3);
        check("toggle_wr_cycles", wr_cycles - wr0, 32'd0);
        check("toggle_no_extra", sb_q.size(), 32'd0);

        // Reset in the second ACCESS cycle: silent abort, outputs cleared
        issue(1'b1, 1'b0, 32'h820, 32'h0, 32'h0, -1);
        @(posedge clk); #1;
        check("pre_rst_strobe", {31'd0, mem_rd}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("arst_strobe", {31'd0, mem_rd}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_pulses", {30'd0, done, error}, 32'd0);
        check("arst_cpu_rdata", cpu_rdata, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unaligned read 0x802
        rd0 = rd_cycles;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        sb_q.push_back('{is_err: 1'b1, rdata: 32'h0});
        issue(1'b1, 1'b0, 32'h802, 32'h0, 32'h0BAD_F00D, 0);
        wait_idle("unaligned_idle");
        check("unaligned_rd_cycles", rd_cycles - rd0, 32'd0);
`else
        sb_q.push_back('{is_err: 1'b0, rdata: 32'h0BAD_F00D});
        issue(1'b1, 1'b0, 32'h802, 32'h0, 32'h0BAD_F00D, 0);
        wait_idle("unaligned_idle");
        check("unaligned_rd_cycles", rd_cycles - rd0, 32'd1);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
